csa_stream_accumulator: RTL
===========================

Name: csa_stream_accumulator

Overview:
- Parametrised, sequential successor to the 32-bit 3:2 carry-save row.
- Accepts a stream of WIDTH-bit operands over a valid/ready handshake, one per cycle, and accumulates them in redundant (sum, carry) form with no carry propagation in the accumulate loop.
- On the last beat of a group, resolves the redundant pair with a chunked carry-propagate adder over WIDTH/CHUNK cycles, then presents the result on a valid/ready output.
- Serves as the multi-operand summation engine for the multiplier/MAC datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits resolved per cycle in the final add. WIDTH % CHUNK == 0 is required; CHUNK == WIDTH gives single-cycle resolve.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  operand.
- in_last  input  1  marks the final beat of a group; sampled with the beat.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  group sum mod 2^WIDTH.
- out_hi  output  8  extension bits (see Optional Feature).

Behaviour:
- Reset (rst_n low at an edge):
  - state=ACC; S=0; C=0; result=0; ext=0.
  - in_ready=1, out_valid=0, out_data=0, out_hi=0.
  - Reset takes effect from any state, including mid-RESOLVE and DONE; any partial group is discarded.
- States: ACC, RESOLVE, DONE.
- ACC:
  - in_ready=1.
  - On in_valid&&in_ready: S <= S^C^d; C <= maj(S,C,d)<<1, truncated to WIDTH. C is stored pre-shifted.
  - Dropped bit maj(S,C,d)[WIDTH-1] feeds ext (feature only).
  - If in_last: go to RESOLVE, chunk index k=0, carry register cr=0.
- RESOLVE:
  - in_ready=0.
  - Each edge: {cr, result[k*CHUNK +: CHUNK]} <= S[chunk k] + C[chunk k] + cr; then k++.
  - After chunk N-1 (N = WIDTH/CHUNK): final cr adds into ext; go to DONE.
- DONE:
  - out_valid=1; out_data and out_hi are held stable while out_ready=0.
  - On out_ready: S, C, ext cleared to 0; go to ACC. in_ready returns the following cycle (no same-cycle bypass).
- Latency:
  - The accepting edge of the last beat is E0. out_valid is visible after edge EN, where N = WIDTH/CHUNK.
  - Throughput: one group per (beats + N + 1) cycles minimum.
- Arithmetic: out_data = (sum of group operands) mod 2^WIDTH, unsigned.
- Boundary conditions:
  - A single-beat group yields out_data = operand.
  - in_valid while in_ready=0 is ignored; the source must hold the beat.
  - out_data is don't-care-free: it holds the last result until overwritten by the next resolve.

Optional Feature:
- Macro: CSA_EXT_EN.
- Defined:
  - An 8-bit counter ext increments for each MSB carry dropped during ACC, plus the final resolve carry.
  - out_hi = ext; {out_hi, out_data} is the exact sum for groups up to 256 beats. Beyond that it wraps mod 2^(WIDTH+8).
- Undefined: no ext logic; out_hi is tied to 0.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
1. Reset, then a single beat 0x1234_5678 with last -> out_valid after 4 edges, out_data=0x1234_5678, out_hi=0.
2. Beats 0xFFFF_FFFF x3, last on the 3rd -> out_data=0xFFFF_FFFD; out_hi=2 with CSA_EXT_EN, 0 without.
3. Beats 1,2,3,4 back-to-back with in_valid held high -> in_ready high for all 4 cycles, out_data=0x0000_000A.
4. out_ready held low 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0. Release; next group 0x10,0x20 -> 0x30 (no residue from the prior group).
5. Assert rst_n=0 during RESOLVE chunk 2 -> next cycle out_valid=0, in_ready=1. Then single beat 0x5 -> out_data=0x5.
6. CHUNK=32, beats 0x8000_0000 x2 -> out_valid 1 edge after the last accept, out_data=0; out_hi=1 with CSA_EXT_EN.

Source files
------------

// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator with chunked carry-propagate resolve.
// Define CSA_EXT_EN to count overflow carries into out_hi.
module csa_stream_accumulator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_hi
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] s_q, c_q, result_q;
  logic [WIDTH-1:0] maj, c_sh;
  logic [KW-1:0]    k_q;
  logic             cr_q;
  logic [CHUNK:0]   csum;
  logic             acc_fire, last_chunk, out_fire;

  // Carry-save step and the current resolve chunk sum
  always_comb begin
    maj  = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);
    c_sh = maj << 1;
    csum = {1'b0, s_q[int'(k_q)*CHUNK +: CHUNK]}
         + {1'b0, c_q[int'(k_q)*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, cr_q};
  end

  assign last_chunk = (k_q == KW'(N - 1));
  assign acc_fire   = in_valid && (state == ACC);
  assign out_fire   = out_ready && (state == DONE);
  assign out_data   = result_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nx = RESOLVE;
      end
      RESOLVE: begin
        if (last_chunk) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ACC;
      end
      default: state_nx = ACC;
    endcase
  end

  // Redundant accumulator, chunk index and resolved result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      k_q      <= '0;
      cr_q     <= 1'b0;
    end else if (acc_fire) begin
      s_q <= s_q ^ c_q ^ in_data;
      c_q <= c_sh;
      if (in_last) begin
        k_q  <= '0;
        cr_q <= 1'b0;
      end
    end else if (state == RESOLVE) begin
      result_q[int'(k_q)*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
      cr_q <= csum[CHUNK];
      k_q  <= k_q + 1'b1;
    end else if (out_fire) begin
      s_q <= '0;
      c_q <= '0;
    end
  end

`ifdef CSA_EXT_EN
  logic [7:0] ext_q;

  // Count carries that fall off the top of the word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q <= '0;
    end else if (acc_fire) begin
      ext_q <= ext_q + 8'(maj[WIDTH-1]);
    end else if (state == RESOLVE && last_chunk) begin
      ext_q <= ext_q + 8'(csum[CHUNK]);
    end else if (out_fire) begin
      ext_q <= '0;
    end
  end

  assign out_hi = ext_q;
`else
  assign out_hi = '0;
`endif

endmodule
